// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage control path and the divider.
// The master issues DIV/DIVU operations; the slave returns busy/ready/result.
`timescale 1ns/1ps
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic               annul;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, annul, a, b,
        input  busy, ready, result
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output busy, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; produces {HI=remainder, LO=quotient}.
// One quotient bit per cycle on operand magnitudes, with sign fix-up on the final iteration.
`timescale 1ns/1ps
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave div_if
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        ON,
        END
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     dividend_q;
    logic [WIDTH-1:0]     divisor_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 busy_q;
    logic                 ready_q;
    logic [2*WIDTH-1:0]   result_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     quo_fix;

    // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        a_neg = div_if.signed_div & div_if.a[WIDTH-1];
        b_neg = div_if.signed_div & div_if.b[WIDTH-1];
        a_mag = a_neg ? -div_if.a : div_if.a;
        b_mag = b_neg ? -div_if.b : div_if.b;
    end

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        rem_shift = {rem_q, dividend_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        rem_d     = rem_shift[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        quo_fix = neg_quo_q ? -quo_d : quo_d;
        rem_fix = neg_rem_q ? -rem_d : rem_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (div_if.start && !div_if.annul) begin
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        quo_q  <= '0;
                        busy_q <= 1'b1;
                        if (div_if.b == '0) begin
                            // Raw dividend kept: it becomes HI unchanged.
                            dividend_q <= div_if.a;
                            divisor_q  <= '0;
                            neg_quo_q  <= 1'b0;
                            neg_rem_q  <= 1'b0;
                            state_q    <= DIVZERO;
                        end else begin
                            dividend_q <= a_mag;
                            divisor_q  <= b_mag;
                            neg_quo_q  <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            state_q    <= ON;
                        end
                    end
                end
                DIVZERO: begin
                    busy_q <= 1'b0;
                    if (div_if.annul) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= {dividend_q, {WIDTH{1'b1}}};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end
                end
                ON: begin
                    if (div_if.annul) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q      <= rem_d;
                        quo_q      <= quo_d;
                        dividend_q <= dividend_q << 1;
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            result_q <= {rem_fix, quo_fix};
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b1;
                            state_q  <= END;
                        end
                    end
                end
                END: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign div_if.busy   = busy_q;
    assign div_if.ready  = ready_q;
    assign div_if.result = result_q;
endmodule
